// File: rtl/rotating_square_pkg.sv
// Shared constants and helpers for the rotating square display.
// Contents:
//   TOP_SQUARE, BOTTOM_SQUARE, BLANK : active-low segment patterns {dp,g,f,e,d,c,b,a}
//   mode_t                           : movement mode (loop / bounce)
//   square_on_col()                  : segment pattern a square at a given position
//                                      contributes to a given column
package rotating_square_pkg;

    localparam logic [7:0] TOP_SQUARE    = 8'b1001_1100;
    localparam logic [7:0] BOTTOM_SQUARE = 8'b1010_0011;
    localparam logic [7:0] BLANK         = 8'hFF;

    typedef enum logic {
        MODE_LOOP   = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_t;

    // Positions 0..n-1 run left to right along the top row; positions n..2n-1
    // run right to left along the bottom row, so the square traces a loop.
    function automatic logic [7:0] square_on_col(input int p, input int col, input int n);
        if (p < n)
            return (p == col) ? TOP_SQUARE : BLANK;
        else
            return ((2 * n - 1 - p) == col) ? BOTTOM_SQUARE : BLANK;
    endfunction

endpackage

// File: rtl/rotating_square_mux_tick_gen.sv
// Free-running timer producing a one-cycle tick.
// Ports:
//   clk   : clock
//   reset : synchronous active-low reset (clears the count)
//   limit : runtime terminal count; tick period is limit+1 cycles
//   tick  : high for the cycle in which count >= limit
// The ">=" compare lets limit shrink mid-count without the counter running
// past it and wrapping.
module tick_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] limit,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    assign tick = (count >= limit);

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (tick)
            count <= '0;
        else
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/rotating_square_mux.sv
// Rotating square on a multiplexed seven-segment display.
// A square walks around a loop of 2*NUM_DIGITS positions (top row left to
// right, bottom row right to left), in loop or bounce mode, with an optional
// second square diametrically opposite.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   enable     : allow the square to move on step ticks
//   cw         : loop direction (1 = forward)
//   mode       : 0 = loop, 1 = bounce
//   dual       : show second square at (pos+N) mod 2N
//   speed      : step period = STEP_DIV >> speed
//   an         : active-low digit enables, an[N-1] is leftmost
//   sseg       : active-low segments {dp,g,f,e,d,c,b,a}
//   pos        : primary square position
//   step       : one-cycle pulse per step tick
module rotating_square_mux
    import rotating_square_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int STEP_DIV    = 50_000_000,
    parameter int REFRESH_DIV = 100_000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            cw,
    input  logic                            mode,
    input  logic                            dual,
    input  logic [1:0]                      speed,
    output logic [NUM_DIGITS-1:0]           an,
    output logic [7:0]                      sseg,
    output logic [$clog2(2*NUM_DIGITS)-1:0] pos,
    output logic                            step
);

    localparam int PW     = $clog2(2 * NUM_DIGITS);
    localparam int LAST   = 2 * NUM_DIGITS - 1;
    localparam int STEP_W = $clog2(STEP_DIV + 1);
    localparam int SCAN_W = $clog2(REFRESH_DIV + 1);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [SCAN_W-1:0] SCAN_LIMIT = SCAN_W'(REFRESH_DIV - 1);

    logic [STEP_W-1:0] step_limit;
    logic              step_tick;
    logic              scan_tick;
    logic [PW-1:0]     pos_q;
    logic              dir_q;      // 1 = forward
    mode_t             mode_q;
    logic              dir_eff;
    logic [IDX_W-1:0]  scan_idx;
    logic [7:0]        seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Period clamped to at least one cycle so large speed values cannot
    // underflow the terminal count.
    always_comb begin
        int period;
        period = STEP_DIV >> speed;
        if (period < 1)
            period = 1;
        step_limit = STEP_W'(period - 1);
    end

    tick_gen #(.WIDTH(STEP_W)) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .limit (step_limit),
        .tick  (step_tick)
    );

    tick_gen #(.WIDTH(SCAN_W)) u_scan_timer (
        .clk   (clk),
        .reset (reset),
        .limit (SCAN_LIMIT),
        .tick  (scan_tick)
    );

    assign step = step_tick;
    assign pos  = pos_q;

    // Entering bounce mode picks up cw on the same edge, so a tick coinciding
    // with the mode change already moves in the new direction.
    assign dir_eff = (mode_t'(mode) == MODE_BOUNCE && mode_q == MODE_LOOP) ? cw : dir_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos_q  <= '0;
            dir_q  <= 1'b1;
            mode_q <= MODE_LOOP;
        end else begin
            mode_q <= mode_t'(mode);
            dir_q  <= dir_eff;
            if (enable && step_tick) begin
                if (mode_t'(mode) == MODE_BOUNCE) begin
                    if (dir_eff) begin
                        if (pos_q == PW'(LAST)) begin
                            pos_q <= PW'(LAST - 1);
                            dir_q <= 1'b0;
                        end else begin
                            pos_q <= pos_q + PW'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_q <= PW'(1);
                            dir_q <= 1'b1;
                        end else begin
                            pos_q <= pos_q - PW'(1);
                        end
                    end
                end else if (cw) begin
                    pos_q <= (pos_q == PW'(LAST)) ? '0 : pos_q + PW'(1);
                end else begin
                    pos_q <= (pos_q == '0) ? PW'(LAST) : pos_q - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            scan_idx <= '0;
        else if (scan_tick)
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end

    // Overlapping squares (odd digit count) AND together, leaving only dp off.
    always_comb begin
        int p2;
        p2       = (int'(pos_q) + NUM_DIGITS) % (2 * NUM_DIGITS);
        seg_next = square_on_col(int'(pos_q), int'(scan_idx), NUM_DIGITS);
        if (dual)
            seg_next = seg_next & square_on_col(p2, int'(scan_idx), NUM_DIGITS);
        an_next  = ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(scan_idx)));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an   <= '1;
            sseg <= BLANK;
        end else begin
            an   <= an_next;
            sseg <= seg_next;
        end
    end

endmodule
